mdio_arbiter: RTL and testbench

Clock-domain-side scheduler for the Clause-22 MDIO master. It shares the single MDIO master between NUM_REQ host requesters using round-robin arbitration. It also inserts a periodic PHY status poll (BMSR, reg 1) that keeps a registered link_up flag current. It sits between the register/CPU ports and the MDIO master, and owns the master's start/addr/write/wr_data inputs exclusively.

---
 rtl/mdio_pkg.sv | 20 ++
 rtl/mdio_rr_arbiter.sv | 31 +++
 rtl/mdio_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mdio_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO scheduler: state encoding, Clause-22
// field widths and the BMSR link-status location.
package mdio_pkg;

  localparam int PHY_W  = 5;
  localparam int REG_W  = 5;
  localparam int ADDR_W = PHY_W + REG_W;
  localparam int DATA_W = 16;

  localparam logic [REG_W-1:0] BMSR_REG = 5'd1;
  localparam int               LINK_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_COMPLETE
  } state_t;

endpackage

// File: rtl/mdio_rr_arbiter.sv
// Round-robin pick: first requesting index at or after i_ptr, wrapping,
// returned as a one-hot grant plus its binary index.
module mdio_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one Clause-22 MDIO master between NUM_REQ hosts (round-robin) and
// a periodic BMSR poll that keeps link_up current.
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int               NUM_REQ        = 2,
  parameter int               MDC_DIV        = 100,
  parameter int               POLL_CYCLES    = 1000000,
  parameter logic [PHY_W-1:0] POLL_PHY       = 5'd0,
  parameter int               TIMEOUT_CYCLES = 200000
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [DATA_W*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      link_up,
  output logic                      link_change,
  output logic                      mdio_start,
  output logic                      mdio_write,
  output logic [ADDR_W-1:0]         mdio_addr,
  output logic [DATA_W-1:0]         mdio_wr_data,
  input  logic                      mdio_done,
  input  logic [DATA_W-1:0]         mdio_rd_data
);

  localparam int          IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] ISSUE_LAST = 32'(2 * MDC_DIV - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES - 1);

  state_t             r_state;
  logic [31:0]        r_cnt;
  logic [31:0]        r_poll_tmr;
  logic               r_poll_pending;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_own_poll;
  logic [IDX_W-1:0]   r_own_idx;
  logic               r_done_m;
  logic               r_done_s;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_any;
  logic               w_wrap;
  logic               w_poll_clr;

  mdio_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_idx_nxt  = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + IDX_W'(1);
  assign w_wrap     = (POLL_CYCLES != 0) && (r_poll_tmr == POLL_LAST);
  assign w_poll_clr = (r_state == S_BUSY) && r_own_poll && (r_done_s || (r_cnt == TO_LAST));

  // mdio_done comes from the MDC domain
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_done_m <= 1'b0;
      r_done_s <= 1'b0;
    end else begin
      r_done_m <= mdio_done;
      r_done_s <= r_done_m;
    end
  end

  // A wrap while a poll is already pending or in flight is absorbed.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_poll_tmr     <= '0;
      r_poll_pending <= 1'b0;
    end else begin
      if (POLL_CYCLES != 0) r_poll_tmr <= w_wrap ? '0 : r_poll_tmr + 32'd1;
      r_poll_pending <= (r_poll_pending | w_wrap) & ~w_poll_clr;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rr_ptr     <= '0;
      r_own_poll   <= 1'b0;
      r_own_idx    <= '0;
      gnt          <= '0;
      ack          <= '0;
      err          <= '0;
      rd_data      <= '0;
      link_up      <= 1'b0;
      link_change  <= 1'b0;
      mdio_start   <= 1'b0;
      mdio_write   <= 1'b0;
      mdio_addr    <= '0;
      mdio_wr_data <= '0;
    end else begin
      gnt         <= '0;
      ack         <= '0;
      err         <= '0;
      link_change <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_poll_pending || w_wrap) begin
            mdio_addr    <= {POLL_PHY, BMSR_REG};
            mdio_write   <= 1'b0;
            mdio_wr_data <= '0;
            r_own_poll   <= 1'b1;
            mdio_start   <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_ISSUE;
          end else if (w_any) begin
            mdio_addr    <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
            mdio_write   <= req_write[w_idx];
            mdio_wr_data <= req_wr_data[int'(w_idx)*DATA_W +: DATA_W];
            gnt          <= w_gnt;
            r_own_poll   <= 1'b0;
            r_own_idx    <= w_idx;
            r_rr_ptr     <= w_idx_nxt;
            mdio_start   <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_cnt == ISSUE_LAST) begin
            mdio_start <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_BUSY;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_BUSY: begin
          if (r_done_s) begin
            // Outputs land in the COMPLETE cycle so a host can drop req on ack
            // before IDLE arbitrates again; rd_data carries host reads only.
            if (r_own_poll) begin
              link_up     <= mdio_rd_data[LINK_BIT];
              link_change <= link_up ^ mdio_rd_data[LINK_BIT];
            end else begin
              ack[r_own_idx] <= 1'b1;
              if (!mdio_write) rd_data <= mdio_rd_data;
            end
            r_state <= S_COMPLETE;
          end else if (r_cnt == TO_LAST) begin
            if (!r_own_poll) err[r_own_idx] <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_COMPLETE: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter with a simple MDIO master model that
// raises done 30 cycles after start drops and returns BMSR or a host value.
module tb_mdio_arbiter;

  localparam logic [4:0] PPHY = 5'd3;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic [1:0]  req = '0;
  logic [19:0] req_addr = '0;
  logic [1:0]  req_write = '0;
  logic [31:0] req_wr_data = '0;
  logic [1:0]  gnt, ack, err;
  logic [15:0] rd_data;
  logic        link_up, link_change, mdio_start, mdio_write;
  logic [9:0]  mdio_addr;
  logic [15:0] mdio_wr_data;
  logic        mdio_done;
  logic [15:0] mdio_rd_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdio_arbiter #(
    .NUM_REQ        (2),
    .MDC_DIV        (10),
    .POLL_CYCLES    (5000),
    .POLL_PHY       (PPHY),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .req          (req),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wr_data  (req_wr_data),
    .gnt          (gnt),
    .ack          (ack),
    .err          (err),
    .rd_data      (rd_data),
    .link_up      (link_up),
    .link_change  (link_change),
    .mdio_start   (mdio_start),
    .mdio_write   (mdio_write),
    .mdio_addr    (mdio_addr),
    .mdio_wr_data (mdio_wr_data),
    .mdio_done    (mdio_done),
    .mdio_rd_data (mdio_rd_data)
  );

  int cyc;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // MDIO master model
  logic        m_hang = 1'b0;
  logic        m_active;
  int          m_cnt;
  logic [15:0] m_bmsr = 16'h7849;
  logic [15:0] m_rdval = 16'h0000;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mdio_done    <= 1'b0;
      mdio_rd_data <= '0;
      m_active     <= 1'b0;
      m_cnt        <= 0;
    end else if (mdio_start) begin
      mdio_done <= 1'b0;
      m_active  <= 1'b1;
      m_cnt     <= 0;
    end else if (m_active && !m_hang) begin
      if (m_cnt == 29) begin
        mdio_done    <= 1'b1;
        m_active     <= 1'b0;
        mdio_rd_data <= mdio_write ? 16'hDEAD :
                        (mdio_addr == {PPHY, 5'd1}) ? m_bmsr : m_rdval;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int   st_run = 0, st_len = 0, n_lc = 0, lc_cyc = 0, n_ovl = 0, n_ack0 = 0, n_errs = 0;
  logic inflight = 1'b0;
  always @(negedge clk) begin
    if (arst_n) begin
      if (mdio_start) st_run++;
      else if (st_run != 0) begin st_len = st_run; st_run = 0; end
      if (link_change) begin n_lc++; lc_cyc = cyc; end
      if (gnt != 0) begin
        if (inflight || !$onehot(gnt)) n_ovl++;
        inflight = 1'b1;
      end
      if (ack != 0 || err != 0) inflight = 1'b0;
      if (ack[0]) n_ack0++;
      if (err != 0) n_errs++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sel(input int kind, input int i);
    case (kind)
      0:       return gnt[i];
      1:       return ack[i];
      default: return err[i];
    endcase
  endfunction

  task automatic wait_ev(input string tag, input int kind, input int i, input int bound, output int n);
    n = 0;
    while (!sel(kind, i) && n < bound) begin @(negedge clk); n++; end
    chk(tag, 32'(sel(kind, i)), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, a0;
    #3 arst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulses", 32'({gnt, ack, err}), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_flags", 32'({link_up, link_change, mdio_start, mdio_write}), 0);
    chk("rst_mdio_addr", 32'(mdio_addr), 0);
    chk("rst_mdio_wr_data", 32'(mdio_wr_data), 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single host write
    req_addr[9:0] = 10'h041; req_write[0] = 1'b1; req_wr_data[15:0] = 16'hA5A5; req[0] = 1'b1;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_start", 32'(mdio_start), 1);
    chk("t1_addr", 32'(mdio_addr), 32'h041);
    chk("t1_write", 32'(mdio_write), 1);
    chk("t1_wr_data", 32'(mdio_wr_data), 32'hA5A5);
    req_addr[9:0] = 10'h3FF; req_write[0] = 1'b0; req_wr_data[15:0] = 16'h0000;
    wait_ev("t1_ack", 1, 0, 300, n);
    chk("t1_ack_latency", n, 53);
    chk("t1_start_len", st_len, 20);
    chk("t1_rd_data_kept", 32'(rd_data), 0);
    chk("t1_addr_held", 32'(mdio_addr), 32'h041);
    req[0] = 1'b0;
    @(negedge clk);

    // host read on requester 1
    req_addr[19:10] = 10'h0A2; req_write[1] = 1'b0; m_rdval = 16'h796D; req[1] = 1'b1;
    wait_ev("t2_gnt", 0, 1, 5, n);
    wait_ev("t2_ack", 1, 1, 300, n);
    chk("t2_ack_vec", 32'(ack), 32'h2);
    chk("t2_rd_data", 32'(rd_data), 32'h796D);
    chk("t2_no_err", n_errs, 0);
    req[1] = 1'b0;
    @(negedge clk);

    // both hosts held: round-robin order 0,1,0,1
    req_addr = {10'h0A2, 10'h041}; req_write = 2'b00; m_rdval = 16'h0BAD; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (gnt == 0 && n < 300) begin @(negedge clk); n++; end
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3) req = 2'b00;
      @(negedge clk);
    end
    wait_ev("rr_last_ack", 1, 1, 300, n);
    @(negedge clk);

    // master never answers: err0 after 1000 BUSY cycles
    m_hang = 1'b1; req_addr[9:0] = 10'h041; req[0] = 1'b1;
    wait_ev("to_gnt", 0, 0, 5, n);
    a0 = n_ack0;
    wait_ev("to_err", 2, 0, 1500, n);
    chk("to_err_latency", n, 1020);
    req[0] = 1'b0; m_hang = 1'b0;
    chk("to_no_ack", n_ack0, a0);
    @(negedge clk);
    req_addr[19:10] = 10'h0A2; m_rdval = 16'h1234; req[1] = 1'b1;
    wait_ev("to_next_gnt", 0, 1, 5, n);
    wait_ev("to_next_ack", 1, 1, 300, n);
    chk("to_next_rd_data", 32'(rd_data), 32'h1234);
    req[1] = 1'b0;

    // first poll (bit2=0): no link change
    while (cyc < 5200) @(negedge clk);
    chk("p1_link_up", 32'(link_up), 0);
    chk("p1_no_change", n_lc, 0);
    m_bmsr = 16'h786D;
    // second poll (bit2=1): link rises in its COMPLETE cycle
    while (cyc < 10200) @(negedge clk);
    chk("p2_change_cnt", n_lc, 1);
    chk("p2_change_cyc", lc_cyc, 10053);
    chk("p2_link_up", 32'(link_up), 1);

    // wrap and req0 in the same cycle: poll first, then req0
    while (cyc != 14999) @(negedge clk);
    req_addr[9:0] = 10'h2C5; req_write[0] = 1'b0; m_rdval = 16'hBEEF; req[0] = 1'b1;
    @(negedge clk);
    chk("sim_no_gnt", 32'(gnt), 0);
    chk("sim_poll_addr", 32'(mdio_addr), 32'h061);
    wait_ev("sim_gnt0", 0, 0, 200, n);
    chk("sim_gnt0_cyc", cyc, 15055);
    chk("sim_host_addr", 32'(mdio_addr), 32'h2C5);
    wait_ev("sim_ack0", 1, 0, 300, n);
    chk("sim_rd_data", 32'(rd_data), 32'hBEEF);
    req[0] = 1'b0;
    chk("p3_no_change", n_lc, 1);
    chk("p3_link_up", 32'(link_up), 1);

    repeat (3) @(negedge clk);
    chk("gnt_onehot_no_overlap", n_ovl, 0);
    chk("err_total", n_errs, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
